// File: rtl/acumulador_flotante.sv
// Sequential float accumulator. Feeds an external combinational adder with the running sum and
// the incoming sample, captures its result on each accepted sample, and hands the final sum plus
// a sticky overflow flag to the consumer over a valid/ready handshake.
module acumulador_flotante #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23,
  parameter int unsigned LEN_W = 8,
  localparam int unsigned W    = 1 + EXP_W + MAN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             in_valid_i,
  input  logic [W-1:0]     in_data_i,
  output logic             in_ready_o,
  output logic [W-1:0]     add_a_o,
  output logic [W-1:0]     add_b_o,
  input  logic [W-1:0]     add_s_i,
  input  logic             add_ovf_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [W-1:0]     out_data_o,
  output logic             out_ovf_o,
  output logic             busy_o
);

  typedef enum logic [1:0] {StIdle, StAcc, StDone} state_e;

  state_e           state_q, state_d;
  logic [W-1:0]     acc_q, acc_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  // Next-state logic: run setup on start, capture adder result per accepted sample.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = len_i;
          state_d = (len_i == '0) ? StDone : StAcc;
        end
      end
      StAcc: begin
        if (in_valid_i) begin
          acc_d = add_s_i;
          ovf_d = ovf_q | add_ovf_i;
          cnt_d = cnt_q - LEN_W'(1);
          // A count of 1 (or a stray 0) always exits, so cnt never wraps.
          if (cnt_q <= LEN_W'(1)) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        if (out_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset aborts any run in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // Outputs are pure decodes of state; the adder operands are wired straight through.
  always_comb begin
    in_ready_o  = (state_q == StAcc);
    out_valid_o = (state_q == StDone);
    busy_o      = (state_q == StAcc) || (state_q == StDone);
    out_data_o  = acc_q;
    out_ovf_o   = ovf_q;
    add_a_o     = acc_q;
    add_b_o     = in_data_i;
  end

endmodule

// File: tb/tb_acumulador_flotante.sv
// Directed bench for acumulador_flotante with a small behavioural float adder in the loop.
module tb_acumulador_flotante;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  len;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic [31:0] add_a, add_b, add_s;
  logic        add_ovf;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_ovf;
  logic        busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  acumulador_flotante #(.EXP_W(8), .MAN_W(23), .LEN_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start),
    .len_i      (len),
    .in_valid_i (in_valid),
    .in_data_i  (in_data),
    .in_ready_o (in_ready),
    .add_a_o    (add_a),
    .add_b_o    (add_b),
    .add_s_i    (add_s),
    .add_ovf_i  (add_ovf),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o (out_data),
    .out_ovf_o  (out_ovf),
    .busy_o     (busy)
  );

  // Same-sign float add with truncation; enough for the positive vectors used here.
  // Returns {overflow, sum}.
  function automatic logic [32:0] fadd(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y;
    logic [8:0]  e;
    logic [24:0] mx, my, s;
    int          sh;
    if (a[30:0] == 31'd0) return {1'b0, b};
    if (b[30:0] == 31'd0) return {1'b0, a};
    if (a[30:23] >= b[30:23]) begin x = a; y = b; end
    else begin x = b; y = a; end
    e  = {1'b0, x[30:23]};
    sh = int'(x[30:23]) - int'(y[30:23]);
    mx = {2'b01, x[22:0]};
    my = {2'b01, y[22:0]} >> sh;
    s  = mx + my;
    if (s[24]) begin
      s = s >> 1;
      e = e + 9'd1;
    end
    return {(e >= 9'd255), x[31], e[7:0], s[22:0]};
  endfunction

  assign {add_ovf, add_s} = fadd(add_a, add_b);

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0; in_data = 32'h1234_5678;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (out_data !== 32'h0) begin bad++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    total++; if (out_ovf !== 1'b0) begin bad++; $display("FAIL reset_out_ovf got=%b exp=0", out_ovf); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (add_a !== 32'h0) begin bad++; $display("FAIL reset_add_a got=%h exp=0", add_a); end
    total++; if (add_b !== 32'h1234_5678) begin bad++; $display("FAIL reset_add_b got=%h exp=12345678", add_b); end
    rst_n = 1'b1;
    in_data = '0;
    @(negedge clk);
  endtask

  // len=2, two back-to-back samples; 7.875 + 0.1875 = 8.0625.
  task automatic test_back_to_back();
    start = 1'b1; len = 8'd2;
    @(negedge clk);
    start = 1'b0;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready got=%b exp=1", in_ready); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_busy got=%b exp=1", busy); end
    in_valid = 1'b1; in_data = 32'h40FC_0000;
    @(negedge clk);
    total++; if (add_a !== 32'h40FC_0000) begin bad++; $display("FAIL b2b_partial got=%h exp=40fc0000", add_a); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_early_valid got=%b exp=0", out_valid); end
    in_data = 32'h3E40_0000;
    @(negedge clk);
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL b2b_out_valid got=%b exp=1", out_valid); end
    total++; if (out_data !== 32'h4101_0000) begin bad++; $display("FAIL b2b_out_data got=%h exp=41010000", out_data); end
    total++; if (out_ovf !== 1'b0) begin bad++; $display("FAIL b2b_out_ovf got=%b exp=0", out_ovf); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_ready_done got=%b exp=0", in_ready); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_released got=%b exp=0", out_valid); end
  endtask

  // len=3, samples 1,2,4 separated by two idle cycles with junk on in_data.
  task automatic test_gaps();
    logic [31:0] smp [3];
    logic [31:0] part[3];
    smp[0] = 32'h3F80_0000; smp[1] = 32'h4000_0000; smp[2] = 32'h4080_0000;
    part[0] = 32'h3F80_0000; part[1] = 32'h4040_0000; part[2] = 32'h40E0_0000;
    start = 1'b1; len = 8'd3;
    @(negedge clk);
    start = 1'b0; len = 8'd1;  // must not affect the run in progress
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = smp[i];
      @(negedge clk);
      in_valid = 1'b0; in_data = 32'h4100_0000 + 32'(i);
      for (int g = 0; g < 2; g++) begin
        total++; if (add_a !== part[i]) begin bad++; $display("FAIL gap_acc[%0d.%0d] got=%h exp=%h", i, g, add_a, part[i]); end
        total++; if (add_b !== 32'h4100_0000 + 32'(i)) begin bad++; $display("FAIL gap_add_b[%0d] got=%h exp=%h", i, add_b, 32'h4100_0000 + 32'(i)); end
        total++; if (out_valid !== (i == 2)) begin bad++; $display("FAIL gap_valid[%0d.%0d] got=%b exp=%b", i, g, out_valid, (i == 2)); end
        @(negedge clk);
      end
    end
    total++; if (out_data !== 32'h40E0_0000) begin bad++; $display("FAIL gap_out_data got=%h exp=40e00000", out_data); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  // len=0 goes straight to DONE with a zero sum; start in DONE is ignored.
  task automatic test_len_zero();
    start = 1'b1; len = 8'd0;
    @(negedge clk);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL len0_valid got=%b exp=1", out_valid); end
    total++; if (out_data !== 32'h0) begin bad++; $display("FAIL len0_data got=%h exp=0", out_data); end
    len = 8'd5;  // start still high while in DONE
    @(negedge clk);
    start = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL len0_start_ignored_valid got=%b exp=1", out_valid); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL len0_start_ignored_ready got=%b exp=0", in_ready); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  // max+max overflows; flag is sticky past the handshake and cleared by the next start.
  task automatic test_overflow();
    start = 1'b1; len = 8'd2;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_data = 32'h7F7F_FFFF;
    @(negedge clk);
    total++; if (out_ovf !== 1'b0) begin bad++; $display("FAIL ovf_first got=%b exp=0", out_ovf); end
    @(negedge clk);
    in_valid = 1'b0;
    total++; if (out_ovf !== 1'b1) begin bad++; $display("FAIL ovf_result got=%b exp=1", out_ovf); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    total++; if (out_ovf !== 1'b1) begin bad++; $display("FAIL ovf_sticky_idle got=%b exp=1", out_ovf); end
    start = 1'b1; len = 8'd1;
    @(negedge clk);
    start = 1'b0;
    total++; if (out_ovf !== 1'b0) begin bad++; $display("FAIL ovf_cleared got=%b exp=0", out_ovf); end
    total++; if (add_a !== 32'h0) begin bad++; $display("FAIL ovf_acc_cleared got=%h exp=0", add_a); end
    in_valid = 1'b1; in_data = 32'h3F80_0000;
    @(negedge clk);
    in_valid = 1'b0;
    total++; if (out_data !== 32'h3F80_0000) begin bad++; $display("FAIL ovf_next_run got=%h exp=3f800000", out_data); end
    total++; if (out_ovf !== 1'b0) begin bad++; $display("FAIL ovf_next_flag got=%b exp=0", out_ovf); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  // DONE holds while out_ready is low; busy falls on the release edge.
  task automatic test_hold_done();
    start = 1'b1; len = 8'd1;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_data = 32'h4000_0000;
    @(negedge clk);
    in_valid = 1'b0; in_data = 32'h3F80_0000;
    for (int i = 0; i < 5; i++) begin
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL hold_valid[%0d] got=%b exp=1", i, out_valid); end
      total++; if (out_data !== 32'h4000_0000) begin bad++; $display("FAIL hold_data[%0d] got=%h exp=40000000", i, out_data); end
      @(negedge clk);
    end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL hold_busy got=%b exp=1", busy); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL hold_busy_fall got=%b exp=0", busy); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL hold_release got=%b exp=0", out_valid); end
  endtask

  // len=255 of 1.0 each: sum 255.0, done only after the last sample.
  task automatic test_max_len();
    start = 1'b1; len = 8'd255;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_data = 32'h3F80_0000;
    repeat (254) @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL maxlen_early got=%b exp=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL maxlen_ready got=%b exp=1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL maxlen_valid got=%b exp=1", out_valid); end
    total++; if (out_data !== 32'h437F_0000) begin bad++; $display("FAIL maxlen_data got=%h exp=437f0000", out_data); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  // Asynchronous reset mid-run, then a clean run with no residue.
  task automatic test_reset_mid();
    start = 1'b1; len = 8'd4;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_data = 32'h4000_0000;
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rstmid_ready got=%b exp=0", in_ready); end
    total++; if (add_a !== 32'h0) begin bad++; $display("FAIL rstmid_add_a got=%h exp=0", add_a); end
    total++; if (out_data !== 32'h0) begin bad++; $display("FAIL rstmid_out_data got=%h exp=0", out_data); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start = 1'b1; len = 8'd1;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_data = 32'h3F80_0000;
    @(negedge clk);
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rstmid_rerun_valid got=%b exp=1", out_valid); end
    total++; if (out_data !== 32'h3F80_0000) begin bad++; $display("FAIL rstmid_rerun_data got=%h exp=3f800000", out_data); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_gaps();
    test_len_zero();
    test_overflow();
    test_hold_done();
    test_max_len();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
